// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit driving a register-file write port.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiply; divide stays iterative.
module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              kill,
  output logic              busy,
  output logic              done,
  output logic              write,
  output logic [ADDR_W-1:0] w_addr,
  output logic [XLEN-1:0]   w_data
);

  localparam int CW = $clog2(XLEN);
  localparam int PW = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              fin_q, fin_d;
  logic              raw_q, raw_d;
  logic              done_q, done_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [XLEN-1:0]   w_data_q, w_data_d;

  logic            is_div, sgn_a, sgn_b;
  logic            div0, ovf, last;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;
  logic [XLEN:0]   msum, dsh, ddiff;
  logic [PW-1:0]   mstep, dstep, acc_nx;
  logic [XLEN-1:0] res;

  function automatic logic [XLEN-1:0] res_of(
    input logic [PW-1:0] acc,
    input logic [2:0]    op,
    input logic          neg,
    input logic          raw
  );
    logic [PW-1:0]   p;
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    logic [XLEN-1:0] o;
    p = neg ? -acc : acc;
    q = acc[XLEN-1:0];
    r = acc[PW-1:XLEN];
    o = q;
    unique case (1'b1)
      raw:                                   o = q;
      !raw && !op[2] && (op[1:0] == 2'b00):  o = p[XLEN-1:0];
      !raw && !op[2] && (op[1:0] != 2'b00):  o = p[PW-1:XLEN];
      !raw && op[2] && op[1]:                o = neg ? -r : r;
      !raw && op[2] && !op[1]:               o = neg ? -q : q;
    endcase
    return o;
  endfunction

  // Operand decode at accept: magnitudes plus sign of the final result.
  always_comb begin
    is_div = funct3[2];
    sgn_a  = rs1_data[XLEN-1] &
             (is_div ? ~funct3[0] : (funct3[1] ^ funct3[0]));
    sgn_b  = rs2_data[XLEN-1] &
             (is_div ? ~funct3[0] : (funct3[1:0] == 2'b01));
    a_mag  = sgn_a ? -rs1_data : rs1_data;
    b_mag  = sgn_b ? -rs2_data : rs2_data;
    div0   = is_div & (rs2_data == '0);
    ovf    = is_div & ~funct3[0] &
             (rs1_data == MIN_NEG) & (rs2_data == '1);
    if (div0) begin
      spec_res = funct3[1] ? rs1_data : '1;
    end else begin
      spec_res = funct3[1] ? '0 : rs1_data;
    end
  end

  // One iteration: shift-add multiply or restoring divide.
  always_comb begin
    msum  = {1'b0, acc_q[PW-1:XLEN]} +
            (acc_q[0] ? {1'b0, a_q} : '0);
    mstep = {msum, acc_q[XLEN-1:1]};
    dsh   = acc_q[PW-1:XLEN-1];
    ddiff = dsh - {1'b0, b_q};
    if (ddiff[XLEN]) begin
      dstep = {dsh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      dstep = {ddiff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
    acc_nx = fin_q ? acc_q : (op_q[2] ? dstep : mstep);
    last   = fin_q | (cnt_q == CW'(XLEN - 1));
    res    = res_of(acc_nx, op_q, neg_q, raw_q);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    fin_d    = fin_q;
    raw_d    = raw_q;
    done_d   = 1'b0;
    write_d  = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    unique case (state_q)
      IDLE: begin
        if (start && !kill) begin
          state_d = CALC;
          op_d    = funct3;
          rd_d    = rd_addr;
          a_d     = a_mag;
          b_d     = b_mag;
          cnt_d   = '0;
          neg_d   = sgn_a ^ (sgn_b & ~(is_div & funct3[1]));
          fin_d   = 1'b0;
          raw_d   = 1'b0;
          acc_d   = {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
          if (div0 || ovf) begin
            fin_d = 1'b1;
            raw_d = 1'b1;
            acc_d = {{XLEN{1'b0}}, spec_res};
          end
`ifdef MULDIV_FAST_MUL_EN
          if (!is_div) begin
            fin_d = 1'b1;
            acc_d = {{XLEN{1'b0}}, a_mag} *
                    {{XLEN{1'b0}}, b_mag};
          end
`endif
        end
      end
      CALC: begin
        if (kill) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = acc_nx;
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            state_d  = DONE;
            cnt_d    = '0;
            done_d   = 1'b1;
            write_d  = |rd_q;
            w_addr_d = rd_q;
            w_data_d = res;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      fin_q    <= 1'b0;
      raw_q    <= 1'b0;
      done_q   <= 1'b0;
      write_q  <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      fin_q    <= fin_d;
      raw_q    <= raw_d;
      done_q   <= done_d;
      write_q  <= write_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q & ~kill;
  assign write  = write_q & ~kill;
  assign w_addr = w_addr_q;
  assign w_data = w_data_q;

endmodule
